// File: rtl/rr_sel4_pkg.sv
// Shared constants and FSM state type for the rr_sel4_arb round-robin capture stage.
package rr_sel4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] one_hot(input logic [SEL_W-1:0] idx);
        logic [NUM_CH-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/mux4_1.sv
// Plain 4:1 word multiplexer that rr_sel4_arb steers through its select output.
module mux4_1 #(
    parameter int W = 4
) (
    input  logic [1:0]   select,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic [W-1:0] in3,
    input  logic [W-1:0] in4,
    output logic [W-1:0] out
);

    always_comb begin
        out = in1;
        case (select)
            2'b00:   out = in1;
            2'b01:   out = in2;
            2'b10:   out = in3;
            default: out = in4;
        endcase
    end

endmodule

// File: rtl/rr_pick4.sv
// Rotate-priority encoder: first requester after the last grant wins.
// With RR_SEL_PRIO_EN defined, req[0] overrides the rotation.
module rr_pick4
    import rr_sel4_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  pick,
    output logic              pick_vld
);

    logic [SEL_W-1:0] idx;

    // Walk from farthest to nearest so the channel right after last is written last and wins.
    always_comb begin
        pick = last;
        idx  = last;
        for (int i = NUM_CH; i >= 1; i--) begin
            idx = last + SEL_W'(i);
            if (req[idx]) begin
                pick = idx;
            end
        end
`ifdef RR_SEL_PRIO_EN
        if (req[0]) begin
            pick = '0;
        end
`endif
        pick_vld = |req;
    end

endmodule

// File: rtl/rr_sel4_arb.sv
// Round-robin arbiter plus one-entry valid/ready capture register around an external mux4_1.
// Optional strict priority for channel 0 is enabled by RR_SEL_PRIO_EN.
module rr_sel4_arb
    import rr_sel4_pkg::*;
#(
    parameter int W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    output logic [SEL_W-1:0]  select,
    input  logic [W-1:0]      mux_out,
    output logic [NUM_CH-1:0] gnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_data,
    output logic [SEL_W-1:0]  out_src
);

    state_t           state;
    state_t           next_state;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] sel_hold;
    logic [SEL_W-1:0] pick;
    logic             pick_vld;
    logic             can_load;
    logic             load;

    rr_pick4 u_pick (
        .req      (req),
        .last     (last),
        .pick     (pick),
        .pick_vld (pick_vld)
    );

    // Gating load with rst_n keeps gnt quiet while reset is held.
    assign can_load  = (state == ST_EMPTY) || out_ready;
    assign load      = can_load && pick_vld && rst_n;
    assign out_valid = (state == ST_FULL);

    always_comb begin
        next_state = state;
        gnt        = '0;
        select     = pick_vld ? pick : sel_hold;
        if (load) begin
            next_state = ST_FULL;
            gnt        = one_hot(pick);
        end else if (can_load) begin
            next_state = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // sel_hold tracks the last granted channel for select; last is the rotation pointer,
    // and the two differ only when channel 0 priority grants skip the pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_src  <= '0;
            sel_hold <= '0;
            last     <= SEL_W'(NUM_CH - 1);
        end else if (load) begin
            out_data <= mux_out;
            out_src  <= pick;
            sel_hold <= pick;
`ifdef RR_SEL_PRIO_EN
            if (pick != '0) begin
                last <= pick;
            end
`else
            last     <= pick;
`endif
        end
    end

endmodule
